// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register their result on the accept edge; MUL is a WIDTH-step shift-add.
// Latency 1 cycle (MUL WIDTH+1); out_ready=0 holds the result and blocks new input.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd2, OP_SLTU = 4'd3,
    OP_SLL  = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_AND  = 4'd7,
    OP_OR   = 4'd8, OP_XOR = 4'd9, OP_MUL = 4'd10
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } alu_out_t;

  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic             lt_s;
  alu_out_t         alu;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh   = b[SHW-1:0];
  // Same sign: the borrow decides; different sign: the negative operand is smaller.
  assign lt_s = (a[MSB] != b[MSB]) ? a[MSB] : diff[WIDTH];

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD: begin
        alu.res = sum[WIDTH-1:0];
        alu.c   = sum[WIDTH];
        alu.v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu.res = diff[WIDTH-1:0];
        alu.c   = diff[WIDTH];
        alu.v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SLT:  alu.res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu.res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      OP_SLL:  alu.res = a << sh;
      OP_SRL:  alu.res = a >> sh;
      OP_SRA:  alu.res = (a >> sh) | (a[MSB] ? ~({WIDTH{1'b1}} >> sh) : '0);
      OP_AND:  alu.res = a & b;
      OP_OR:   alu.res = a | b;
      OP_XOR:  alu.res = a ^ b;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (op == OP_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              result    <= alu.res;
              zero      <= (alu.res == '0);
              carry     <= alu.c;
              overflow  <= alu.v;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // The final iteration's sum goes straight to the output register.
          if (cnt == CNT_LAST) begin
            result    <= acc_nxt;
            zero      <= (acc_nxt == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq at WIDTH=8 against an arithmetic reference model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on an 8-bit machine.
  function automatic void model(input int opc, input int ai, input int bi,
                                output int res, output int cy, output int ov);
    int sa, sb, sh, t;
    sa  = (ai >= 128) ? ai - 256 : ai;
    sb  = (bi >= 128) ? bi - 256 : bi;
    sh  = bi % 8;
    res = 0; cy = 0; ov = 0;
    case (opc)
      0: begin
        t   = ai + bi;
        res = t % 256;
        cy  = t / 256;
        ov  = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
      end
      1: begin
        res = (ai - bi + 256) % 256;
        cy  = (ai < bi) ? 1 : 0;
        ov  = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
      end
      2:  res = (sa < sb) ? 1 : 0;
      3:  res = (ai < bi) ? 1 : 0;
      4:  res = (ai << sh) % 256;
      5:  res = ai >> sh;
      6:  res = (sa >>> sh) & 255;
      7:  res = ai & bi;
      8:  res = ai | bi;
      9:  res = ai ^ bi;
      10: res = (ai * bi) % 256;
      default: res = 0;
    endcase
  endfunction

  task automatic do_op(input int opc, input int ai, input int bi, input int hold);
    int  er, ec, ev, lat;
    bit  rdy_bad, hold_bad;
    string tg;
    model(opc, ai, bi, er, ec, ev);
    tg = $sformatf("op%0d_%0h_%0h", opc, ai, bi);
    op = 4'(opc); a = 8'(ai); b = 8'(bi); in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tg, "_accept_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
    lat = 1; rdy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    check({tg, "_latency"}, 32'(lat), (opc == 10) ? 32'd9 : 32'd1);
    check({tg, "_in_ready_low"}, 32'(rdy_bad | in_ready), 32'd0);
    check({tg, "_result"}, 32'(result), 32'(er));
    check({tg, "_zero"}, 32'(zero), (er == 0) ? 32'd1 : 32'd0);
    check({tg, "_carry"}, 32'(carry), 32'(ec));
    check({tg, "_overflow"}, 32'(overflow), 32'(ev));
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== 8'(er)) hold_bad = 1'b1;
    end
    if (hold > 0) check({tg, "_hold_stable"}, 32'(hold_bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tg, "_release_valid"}, 32'(out_valid), 32'd0);
    check({tg, "_release_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, zero, carry, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 8'hFF, 8'h01, 0);
    do_op(0, 8'h7F, 8'h01, 0);
    do_op(1, 8'h03, 8'h05, 0);
    do_op(2, 8'hFE, 8'h01, 0);
    do_op(3, 8'hFE, 8'h01, 0);
    for (int s = 4; s <= 6; s++) begin
      do_op(s, 8'h96, 8'h0B, 0);
      do_op(s, 8'h96, 8'h00, 0);
    end
    do_op(6, 8'h80, 8'h07, 0);
    do_op(10, 8'h0D, 8'h0B, 0);
    do_op(10, 8'h00, 8'h55, 0);
    do_op(12, 8'h00, 8'h00, 0);

    // Back-pressure with a competing request held on the input.
    op = 4'd9; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_result", 32'(result), 32'hCC);
    op = 4'd0; a = 8'h01; b = 8'h02;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== 8'hCC) bad = 1'b1;
    end
    check("bp_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", 32'(result), 32'h03);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a multiply.
    op = 4'd10; a = 8'h0D; b = 8'h0B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", 32'(in_ready | out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {29'd0, zero, carry, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1'b1;
    end
    check("abort_no_result", 32'(bad), 32'd0);
    do_op(0, 8'h21, 8'h13, 0);

    for (int i = 0; i < 40; i++)
      do_op(int'($urandom_range(15, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(255, 0)), int'($urandom_range(2, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
